freq_duty_div_mc: RTL and testbench

Multi-channel programmable clock divider with per-channel period and duty control, the parametrised successor to the single-channel frequency/duty divider. Each channel produces a registered divided clock and a period-start tick from the one system clock. Configuration goes through a valid/ready write port into per-channel shadow registers and takes effect only at a period boundary, so outputs never glitch or truncate mid-period. Sits in the clock/timing subsystem and feeds PWM outputs, sampling strobes and slow peripheral clocks.

---
 rtl/freq_duty_div_mc.sv | 133 +++++++++++++
 tb/tb_freq_duty_div_mc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_duty_div_mc.sv
// rtl/freq_duty_div_mc.sv - multi-channel programmable clock divider with per-channel period/duty
// Each channel has shadowed config that is applied only at a period boundary or while idle.
module freq_duty_div_mc #(
  parameter int CHANNELS   = 4,
  parameter int COUNT_BITS = 16,
  parameter int RST_PERIOD = 1,
  parameter int RST_HIGH   = 1,
  parameter int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [CHANNELS-1:0]   i_enable,
  input  logic                  i_cfg_valid,
  input  logic [CH_BITS-1:0]    i_cfg_ch,
  input  logic [COUNT_BITS-1:0] i_cfg_period,
  input  logic [COUNT_BITS-1:0] i_cfg_high,
  output logic                  o_cfg_ready,
  output logic [CHANNELS-1:0]   o_cfg_pending,
  output logic [CHANNELS-1:0]   o_div_clk,
  output logic [CHANNELS-1:0]   o_period_tick
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic [CHANNELS-1:0] pend_vec;
  logic                cfg_ready;

  // Indices at or beyond CHANNELS match no channel, so they read ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_cfg_ch == CH_BITS'(c)) begin
        cfg_ready = ~pend_vec[c];
      end
    end
  end

  assign o_cfg_ready   = cfg_ready;
  assign o_cfg_pending = pend_vec;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    state_t                state_q, state_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [COUNT_BITS-1:0] p_act_q, p_act_d, h_act_q, h_act_d;
    logic [COUNT_BITS-1:0] p_sh_q, p_sh_d, h_sh_q, h_sh_d;
    logic                  pend_q, pend_d;
    logic                  div_q, div_d;
    logic                  tick_q, tick_d;
    logic                  wr_acc;
    logic                  apply;

    assign wr_acc = i_cfg_valid && (i_cfg_ch == CH_BITS'(g)) && !pend_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_act_d = p_act_q;
      h_act_d = h_act_q;
      p_sh_d  = p_sh_q;
      h_sh_d  = h_sh_q;
      pend_d  = pend_q;
      apply   = 1'b0;
      div_d   = 1'b0;
      tick_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          apply = pend_q;
          if (i_enable[g]) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (!i_enable[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == p_act_q) begin
            cnt_d = '0;
            apply = pend_q;
          end else begin
            cnt_d = cnt_q + COUNT_BITS'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (apply) begin
        p_act_d = p_sh_q;
        h_act_d = h_sh_q;
        pend_d  = 1'b0;
      end
      // A write can only land when nothing is pending, so it never races an apply.
      if (wr_acc) begin
        p_sh_d = i_cfg_period;
        h_sh_d = i_cfg_high;
        pend_d = 1'b1;
      end
      if (state_d == ST_RUN) begin
        div_d  = (cnt_d < h_act_d);
        tick_d = (cnt_d == '0);
      end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        p_act_q <= COUNT_BITS'(RST_PERIOD);
        h_act_q <= COUNT_BITS'(RST_HIGH);
        p_sh_q  <= COUNT_BITS'(RST_PERIOD);
        h_sh_q  <= COUNT_BITS'(RST_HIGH);
        pend_q  <= 1'b0;
        div_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        p_act_q <= p_act_d;
        h_act_q <= h_act_d;
        p_sh_q  <= p_sh_d;
        h_sh_q  <= h_sh_d;
        pend_q  <= pend_d;
        div_q   <= div_d;
        tick_q  <= tick_d;
      end
    end

    assign pend_vec[g]      = pend_q;
    assign o_div_clk[g]     = div_q;
    assign o_period_tick[g] = tick_q;
  end

endmodule

// File: tb/tb_freq_duty_div_mc.sv
// tb/tb_freq_duty_div_mc.sv - self-checking bench for freq_duty_div_mc
// A period-age model checks every cycle; literal sequences pin the model.
module tb_freq_duty_div_mc;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  en;
  logic        valid;
  logic [1:0]  ch;
  logic [15:0] per, hi;
  logic        ready;
  logic [3:0]  pend, divc, tick;

  logic [2:0]  en3;
  logic        valid3;
  logic [1:0]  ch3;
  logic [15:0] per3, hi3;
  logic        ready3;
  logic [2:0]  pend3, div3, tick3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  freq_duty_div_mc #(.CHANNELS(4), .COUNT_BITS(16), .RST_PERIOD(1), .RST_HIGH(1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en), .i_cfg_valid(valid), .i_cfg_ch(ch),
    .i_cfg_period(per), .i_cfg_high(hi), .o_cfg_ready(ready), .o_cfg_pending(pend),
    .o_div_clk(divc), .o_period_tick(tick)
  );

  freq_duty_div_mc #(.CHANNELS(3), .COUNT_BITS(16), .RST_PERIOD(1), .RST_HIGH(1)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en3), .i_cfg_valid(valid3), .i_cfg_ch(ch3),
    .i_cfg_period(per3), .i_cfg_high(hi3), .o_cfg_ready(ready3), .o_cfg_pending(pend3),
    .o_div_clk(div3), .o_period_tick(tick3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: age counts cycles since the current period began; a period lasts P+1 cycles.
  int m_run[4], m_age[4], m_p[4], m_h[4], m_sp[4], m_sh[4], m_pend[4];

  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge rstn);
      for (int c = 0; c < 4; c++) begin
        if (!rstn) begin
          m_run[c] = 0; m_age[c] = 0; m_p[c] = 1; m_h[c] = 1;
          m_sp[c] = 1; m_sh[c] = 1; m_pend[c] = 0;
        end else begin
          acc = valid && (int'(ch) == c) && (m_pend[c] == 0);
          if (m_run[c] == 0) begin
            if (m_pend[c] != 0) begin m_p[c] = m_sp[c]; m_h[c] = m_sh[c]; m_pend[c] = 0; end
            if (en[c]) begin m_run[c] = 1; m_age[c] = 0; end
          end else if (!en[c]) begin
            m_run[c] = 0;
          end else begin
            m_age[c] = m_age[c] + 1;
            if (m_age[c] == m_p[c] + 1) begin
              m_age[c] = 0;
              if (m_pend[c] != 0) begin m_p[c] = m_sp[c]; m_h[c] = m_sh[c]; m_pend[c] = 0; end
            end
          end
          if (acc) begin m_sp[c] = int'(per); m_sh[c] = int'(hi); m_pend[c] = 1; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        for (int c = 0; c < 4; c++) begin
          check($sformatf("model_div%0d", c), divc[c],
                (m_run[c] != 0 && m_age[c] < m_h[c]) ? 1 : 0);
          check($sformatf("model_tick%0d", c), tick[c],
                (m_run[c] != 0 && m_age[c] == 0) ? 1 : 0);
          check($sformatf("model_pend%0d", c), pend[c], m_pend[c] != 0 ? 1 : 0);
        end
        check("model_ready", ready, (m_pend[ch] != 0) ? 0 : 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input int c, input int p, input int h);
    valid = 1'b1; ch = 2'(c); per = 16'(p); hi = 16'(h);
    step();
    valid = 1'b0;
  endtask

  task automatic expect_seq(input string name, input int c, input int n,
                            input logic [31:0] dpat, input logic [31:0] tpat);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_div[%0d]", name, i), divc[c], dpat[n-1-i]);
      check($sformatf("%s_tick[%0d]", name, i), tick[c], tpat[n-1-i]);
      step();
    end
  endtask

  initial begin
    int k;
    rstn = 1'b0; en = '0; valid = 1'b0; ch = '0; per = '0; hi = '0;
    en3 = '0; valid3 = 1'b0; ch3 = '0; per3 = '0; hi3 = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_div", divc, 0);
    check("rst_tick", tick, 0);
    check("rst_pend", pend, 0);
    check("rst_ready", ready, 1);
    check("rst_div3", div3, 0);
    rstn = 1'b1;
    step();

    en[0] = 1'b1;
    step();
    expect_seq("ch0_default", 0, 4, 4'b1010, 4'b1010);

    cfg_write(1, 4, 2);
    check("ch1_pend_after_wr", pend[1], 1);
    step();
    check("ch1_pend_applied_idle", pend[1], 0);
    en[1] = 1'b1;
    step();
    expect_seq("ch1_p4h2", 1, 10, 10'b1100011000, 10'b1000010000);

    step();
    step();
    cfg_write(1, 9, 7);
    check("ch1_pend_mid", pend[1], 1);
    valid = 1'b1; ch = 2'd1; per = 16'd2; hi = 16'd1;
    #1;
    check("ch1_ready_busy", ready, 0);
    step();
    valid = 1'b0;
    check("ch1_pend_hold", pend[1], 1);
    k = 0;
    while (pend[1] && k < 20) begin step(); k++; end
    check("ch1_pend_timeout", pend[1], 0);
    expect_seq("ch1_p9h7", 1, 10, 10'b1111111000, 10'b1000000000);

    cfg_write(2, 3, 0);
    step();
    en[2] = 1'b1;
    step();
    expect_seq("ch2_h0", 2, 6, 6'b000000, 6'b100010);
    en[2] = 1'b0;
    step();
    check("ch2_off_div", divc[2], 0);
    check("ch2_off_tick", tick[2], 0);
    cfg_write(2, 3, 5);
    step();
    en[2] = 1'b1;
    step();
    expect_seq("ch2_h_gt_p", 2, 5, 5'b11111, 5'b10001);
    en[2] = 1'b0;
    step();
    cfg_write(2, 0, 1);
    step();
    en[2] = 1'b1;
    step();
    expect_seq("ch2_p0", 2, 5, 5'b11111, 5'b11111);

    en[3] = 1'b1;
    step();
    check("ch3_first_tick", tick[3], 1);
    step();
    cfg_write(3, 2, 1);
    check("ch3_pend_wrap_wr", pend[3], 1);
    expect_seq("ch3_wrap_wr", 3, 8, 8'b10100100, 8'b10100100);

    valid3 = 1'b1; ch3 = 2'd3; per3 = 16'd7; hi3 = 16'd7;
    #1;
    check("dut3_oob_ready", ready3, 1);
    step();
    valid3 = 1'b0;
    check("dut3_oob_pend", pend3, 0);
    en3[0] = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut3_ch0_div[%0d]", i), div3[0], (i % 2 == 0) ? 1 : 0);
      step();
    end

    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_div", divc, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_pend", pend, 0);
    check("async_rst_ready", ready, 1);
    en = '0;
    en3 = '0;
    step();
    step();
    rstn = 1'b1;
    step();
    en[1] = 1'b1;
    step();
    expect_seq("ch1_after_rst", 1, 4, 4'b1010, 4'b1010);
    check("after_rst_pend", pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
